// File: rtl/scr1_sha256_pkg.sv
// Shared types, constants and round functions for the SHA-256 compression engine.
// Optional build macro: SCR1_SHA256_BYTE_SWAP_EN (byte-reverses message words at latch).
package scr1_sha256_pkg;

  localparam int unsigned SCR1_SHA256_WORD_W      = 32;
  localparam int unsigned SCR1_SHA256_BLOCK_WORDS = 16;
  localparam int unsigned SCR1_SHA256_STATE_WORDS = 8;
  localparam int unsigned SCR1_SHA256_ROUNDS      = 64;
  localparam int unsigned SCR1_SHA256_BLOCK_W     = SCR1_SHA256_WORD_W * SCR1_SHA256_BLOCK_WORDS;
  localparam int unsigned SCR1_SHA256_STATE_W     = SCR1_SHA256_WORD_W * SCR1_SHA256_STATE_WORDS;
  localparam int unsigned SCR1_SHA256_T_W         = 6;

  typedef enum logic [1:0] {
    SCR1_SHA256_FSM_IDLE  = 2'd0,
    SCR1_SHA256_FSM_ROUND = 2'd1,
    SCR1_SHA256_FSM_FINAL = 2'd2
  } type_scr1_sha256_fsm_e;

  typedef logic [SCR1_SHA256_WORD_W-1:0]                              type_scr1_sha256_word_t;
  typedef logic [SCR1_SHA256_BLOCK_WORDS-1:0][SCR1_SHA256_WORD_W-1:0] type_scr1_sha256_block_t;
  typedef logic [SCR1_SHA256_STATE_WORDS-1:0][SCR1_SHA256_WORD_W-1:0] type_scr1_sha256_state_t;

  localparam type_scr1_sha256_word_t SCR1_SHA256_H0 = 32'h6a09e667;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H1 = 32'hbb67ae85;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H2 = 32'h3c6ef372;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H3 = 32'ha54ff53a;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H4 = 32'h510e527f;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H5 = 32'h9b05688c;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H6 = 32'h1f83d9ab;
  localparam type_scr1_sha256_word_t SCR1_SHA256_H7 = 32'h5be0cd19;

  function automatic type_scr1_sha256_word_t sha256_rotr(type_scr1_sha256_word_t x, int unsigned n);
    return (x >> n) | (x << (SCR1_SHA256_WORD_W - n));
  endfunction

  function automatic type_scr1_sha256_word_t sha256_big_sigma0(type_scr1_sha256_word_t x);
    return sha256_rotr(x, 2) ^ sha256_rotr(x, 13) ^ sha256_rotr(x, 22);
  endfunction

  function automatic type_scr1_sha256_word_t sha256_big_sigma1(type_scr1_sha256_word_t x);
    return sha256_rotr(x, 6) ^ sha256_rotr(x, 11) ^ sha256_rotr(x, 25);
  endfunction

  function automatic type_scr1_sha256_word_t sha256_small_sigma0(type_scr1_sha256_word_t x);
    return sha256_rotr(x, 7) ^ sha256_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic type_scr1_sha256_word_t sha256_small_sigma1(type_scr1_sha256_word_t x);
    return sha256_rotr(x, 17) ^ sha256_rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic type_scr1_sha256_word_t sha256_ch(type_scr1_sha256_word_t e,
                                                        type_scr1_sha256_word_t f,
                                                        type_scr1_sha256_word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic type_scr1_sha256_word_t sha256_maj(type_scr1_sha256_word_t a,
                                                         type_scr1_sha256_word_t b,
                                                         type_scr1_sha256_word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic type_scr1_sha256_word_t sha256_bswap32(type_scr1_sha256_word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/scr1_sha256_if.sv
// Request/result bundle between the accelerator register file (master) and the SHA-256 core (slave).
interface scr1_sha256_if;
  import scr1_sha256_pkg::*;

  logic                           start;
  logic                           abort;
  logic [SCR1_SHA256_BLOCK_W-1:0] block_in;
  logic [SCR1_SHA256_STATE_W-1:0] state_in;
  logic                           busy;
  logic                           done;
  logic [SCR1_SHA256_STATE_W-1:0] state_out;

  modport master (output start, abort, block_in, state_in,
                  input  busy, done, state_out);
  modport slave  (input  start, abort, block_in, state_in,
                  output busy, done, state_out);
endinterface

// File: rtl/scr1_sha256_k_rom.sv
// SHA-256 round constant table K[t], purely combinational.
module scr1_sha256_k_rom
  import scr1_sha256_pkg::*;
(
  input  logic [SCR1_SHA256_T_W-1:0] t,
  output type_scr1_sha256_word_t     k_c
);

  always_comb begin
    k_c = '0;
    case (t)
      6'd0:  k_c = 32'h428a2f98;  6'd1:  k_c = 32'h71374491;
      6'd2:  k_c = 32'hb5c0fbcf;  6'd3:  k_c = 32'he9b5dba5;
      6'd4:  k_c = 32'h3956c25b;  6'd5:  k_c = 32'h59f111f1;
      6'd6:  k_c = 32'h923f82a4;  6'd7:  k_c = 32'hab1c5ed5;
      6'd8:  k_c = 32'hd807aa98;  6'd9:  k_c = 32'h12835b01;
      6'd10: k_c = 32'h243185be;  6'd11: k_c = 32'h550c7dc3;
      6'd12: k_c = 32'h72be5d74;  6'd13: k_c = 32'h80deb1fe;
      6'd14: k_c = 32'h9bdc06a7;  6'd15: k_c = 32'hc19bf174;
      6'd16: k_c = 32'he49b69c1;  6'd17: k_c = 32'hefbe4786;
      6'd18: k_c = 32'h0fc19dc6;  6'd19: k_c = 32'h240ca1cc;
      6'd20: k_c = 32'h2de92c6f;  6'd21: k_c = 32'h4a7484aa;
      6'd22: k_c = 32'h5cb0a9dc;  6'd23: k_c = 32'h76f988da;
      6'd24: k_c = 32'h983e5152;  6'd25: k_c = 32'ha831c66d;
      6'd26: k_c = 32'hb00327c8;  6'd27: k_c = 32'hbf597fc7;
      6'd28: k_c = 32'hc6e00bf3;  6'd29: k_c = 32'hd5a79147;
      6'd30: k_c = 32'h06ca6351;  6'd31: k_c = 32'h14292967;
      6'd32: k_c = 32'h27b70a85;  6'd33: k_c = 32'h2e1b2138;
      6'd34: k_c = 32'h4d2c6dfc;  6'd35: k_c = 32'h53380d13;
      6'd36: k_c = 32'h650a7354;  6'd37: k_c = 32'h766a0abb;
      6'd38: k_c = 32'h81c2c92e;  6'd39: k_c = 32'h92722c85;
      6'd40: k_c = 32'ha2bfe8a1;  6'd41: k_c = 32'ha81a664b;
      6'd42: k_c = 32'hc24b8b70;  6'd43: k_c = 32'hc76c51a3;
      6'd44: k_c = 32'hd192e819;  6'd45: k_c = 32'hd6990624;
      6'd46: k_c = 32'hf40e3585;  6'd47: k_c = 32'h106aa070;
      6'd48: k_c = 32'h19a4c116;  6'd49: k_c = 32'h1e376c08;
      6'd50: k_c = 32'h2748774c;  6'd51: k_c = 32'h34b0bcb5;
      6'd52: k_c = 32'h391c0cb3;  6'd53: k_c = 32'h4ed8aa4a;
      6'd54: k_c = 32'h5b9cca4f;  6'd55: k_c = 32'h682e6ff3;
      6'd56: k_c = 32'h748f82ee;  6'd57: k_c = 32'h78a5636f;
      6'd58: k_c = 32'h84c87814;  6'd59: k_c = 32'h8cc70208;
      6'd60: k_c = 32'h90befffa;  6'd61: k_c = 32'ha4506ceb;
      6'd62: k_c = 32'hbef9a3f7;  6'd63: k_c = 32'hc67178f2;
      default: k_c = '0;
    endcase
  end

endmodule

// File: rtl/scr1_sha256_core.sv
// Iterative SHA-256 compression engine: one round per clock, result = compression + feed-forward.
// Build macro SCR1_SHA256_BYTE_SWAP_EN byte-reverses each block_in word when it is latched.
module scr1_sha256_core
  import scr1_sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  scr1_sha256_if.slave sha_if
);

  localparam logic [1:0] FSM_IDLE  = SCR1_SHA256_FSM_IDLE;
  localparam logic [1:0] FSM_ROUND = SCR1_SHA256_FSM_ROUND;
  localparam logic [1:0] FSM_FINAL = SCR1_SHA256_FSM_FINAL;
  localparam logic [SCR1_SHA256_T_W-1:0] T_LAST = SCR1_SHA256_T_W'(SCR1_SHA256_ROUNDS - 1);

  logic [1:0]                  fsm_q, fsm_d;
  logic [SCR1_SHA256_T_W-1:0]  t_q, t_d;
  type_scr1_sha256_block_t     w_q, w_d;     // element 15 holds W[0]
  type_scr1_sha256_state_t     wv_q, wv_d;   // element 7 = a ... element 0 = h
  type_scr1_sha256_state_t     hq_q, hq_d;
  type_scr1_sha256_state_t     state_out_q, state_out_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  type_scr1_sha256_word_t k_c;
  type_scr1_sha256_word_t t1_c, t2_c, w_next_c;
  type_scr1_sha256_block_t blk_c;

  scr1_sha256_k_rom u_k_rom (
    .t   (t_q),
    .k_c (k_c)
  );

  // Round datapath: a=wv[7] .. h=wv[0]; W[j] sits at w_q[15-j]
  always_comb begin
    t1_c = wv_q[0] + sha256_big_sigma1(wv_q[3]) + sha256_ch(wv_q[3], wv_q[2], wv_q[1])
         + k_c + w_q[15];
    t2_c = sha256_big_sigma0(wv_q[7]) + sha256_maj(wv_q[7], wv_q[6], wv_q[5]);
    w_next_c = sha256_small_sigma1(w_q[1]) + w_q[6] + sha256_small_sigma0(w_q[14]) + w_q[15];
  end

  always_comb begin
    blk_c = sha_if.block_in;
`ifdef SCR1_SHA256_BYTE_SWAP_EN
    for (int i = 0; i < int'(SCR1_SHA256_BLOCK_WORDS); i++) begin
      blk_c[i] = sha256_bswap32(blk_c[i]);
    end
`endif
  end

  // Next-state and output logic
  always_comb begin
    fsm_d       = fsm_q;
    t_d         = t_q;
    w_d         = w_q;
    wv_d        = wv_q;
    hq_d        = hq_q;
    state_out_d = state_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (fsm_q)
      FSM_IDLE: begin
        busy_d = 1'b0;
        if (sha_if.start && !sha_if.abort) begin
          w_d    = blk_c;
          hq_d   = sha_if.state_in;
          wv_d   = sha_if.state_in;
          t_d    = '0;
          busy_d = 1'b1;
          fsm_d  = FSM_ROUND;
        end
      end
      FSM_ROUND: begin
        if (sha_if.abort) begin
          busy_d = 1'b0;
          fsm_d  = FSM_IDLE;
        end else begin
          wv_d = {t1_c + t2_c, wv_q[7], wv_q[6], wv_q[5], wv_q[4] + t1_c,
                  wv_q[3], wv_q[2], wv_q[1]};
          w_d  = {w_q[14:0], w_next_c};
          if (t_q == T_LAST) begin
            fsm_d = FSM_FINAL;
          end else begin
            t_d = t_q + SCR1_SHA256_T_W'(1);
          end
        end
      end
      FSM_FINAL: begin
        busy_d = 1'b0;
        fsm_d  = FSM_IDLE;
        if (!sha_if.abort) begin
          for (int i = 0; i < int'(SCR1_SHA256_STATE_WORDS); i++) begin
            state_out_d[i] = hq_q[i] + wv_q[i];
          end
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
        fsm_d  = FSM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= FSM_IDLE;
      t_q         <= '0;
      w_q         <= '0;
      wv_q        <= '0;
      hq_q        <= '0;
      state_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      t_q         <= t_d;
      w_q         <= w_d;
      wv_q        <= wv_d;
      hq_q        <= hq_d;
      state_out_q <= state_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sha_if.busy      = busy_q;
  assign sha_if.done      = done_q;
  assign sha_if.state_out = state_out_q;

endmodule

// File: tb/tb_scr1_sha256_core.sv
// Self-checking bench for scr1_sha256_core: known digests plus random blocks against a reference model.
module tb_scr1_sha256_core;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  logic [255:0] last_out;

  scr1_sha256_if sha_if ();

  scr1_sha256_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sha_if (sha_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Words as the engine sees them after its optional input byte swap (an involution)
  function automatic logic [511:0] dut_view(logic [511:0] blk);
    logic [511:0] r;
    r = blk;
`ifdef SCR1_SHA256_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = {blk[32*i +: 8], blk[32*i+8 +: 8], blk[32*i+16 +: 8], blk[32*i+24 +: 8]};
    end
`endif
    return r;
  endfunction

  // Textbook compression: full 64-entry message schedule, then 64 rounds, then feed-forward
  function automatic logic [255:0] ref_compress(logic [511:0] blk, logic [255:0] st);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) | (~v[4] & v[6]))
         + K_TAB[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) | (v[2] & (v[0] | v[1])));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [255:0] rand_state();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom();
    return s;
  endfunction

  // Launch one block at the next edge; optional ignored start and abort at cycle offsets (-1 = none)
  task automatic run_block(input logic [511:0] blk, input logic [255:0] st, input logic [255:0] exp,
                           input int extra_start_at, input int abort_at);
    int cyc;
    bit seen, aborted, busy_drop, any_done;
    sha_if.block_in = blk;
    sha_if.state_in = st;
    sha_if.start    = 1'b1;
    @(posedge clk); #1;
    sha_if.start    = 1'b0;
    sha_if.block_in = rand_block();
    sha_if.state_in = rand_state();
    check_val("busy_rise", 256'(sha_if.busy), 256'd1);
    check_val("done_single_pulse", 256'(sha_if.done), 256'd0);
    cyc = 0; seen = 1'b0; aborted = 1'b0; busy_drop = 1'b0;
    while (!seen && !aborted && cyc < 100) begin
      sha_if.start = (cyc == extra_start_at);
      sha_if.abort = (cyc == abort_at);
      @(posedge clk); #1;
      cyc++;
      sha_if.start = 1'b0;
      sha_if.abort = 1'b0;
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        aborted = 1'b1;
        check_val("abort_busy", 256'(sha_if.busy), 256'd0);
        check_val("abort_done", 256'(sha_if.done), 256'd0);
      end else begin
        seen = sha_if.done;
        if (!seen && !sha_if.busy) busy_drop = 1'b1;
      end
    end
    if (aborted) begin
      any_done = 1'b0;
      repeat (70) begin
        @(posedge clk); #1;
        any_done |= sha_if.done;
      end
      check_val("abort_no_done", 256'(any_done), 256'd0);
      check_val("abort_hold_out", sha_if.state_out, last_out);
    end else begin
      check_val("busy_hold", 256'(busy_drop), 256'd0);
      check_val("latency", 256'(cyc), 256'd65);
      check_val("digest", sha_if.state_out, exp);
      check_val("busy_fall", 256'(sha_if.busy), 256'd0);
      last_out = exp;
    end
  endtask

  initial begin
    logic [511:0] blk;
    logic [255:0] st;
    int extra;
    n_checks = 0;
    n_fails  = 0;
    last_out = '0;
    rst_n = 1'b0;
    sha_if.start = 1'b0;
    sha_if.abort = 1'b0;
    sha_if.block_in = '0;
    sha_if.state_in = '0;
    repeat (2) @(posedge clk); #1;
    check_val("rst_busy", 256'(sha_if.busy), 256'd0);
    check_val("rst_done", 256'(sha_if.done), 256'd0);
    check_val("rst_state_out", sha_if.state_out, 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(dut_view(ABC_BLK), IV, ABC_DIG, -1, -1);
    run_block(dut_view(EMPTY_BLK), IV, EMPTY_DIG, -1, -1);
    run_block(dut_view(ABC_BLK), IV, ABC_DIG, 10, -1);
    blk = rand_block();
    run_block(blk, last_out, ref_compress(dut_view(blk), last_out), -1, -1);

    run_block(dut_view(EMPTY_BLK), IV, EMPTY_DIG, -1, 30);
    run_block(dut_view(ABC_BLK), IV, ABC_DIG, -1, -1);

    // Abort and start together in IDLE: nothing launches
    repeat (3) @(posedge clk); #1;
    sha_if.block_in = dut_view(EMPTY_BLK);
    sha_if.state_in = IV;
    sha_if.start = 1'b1;
    sha_if.abort = 1'b1;
    @(posedge clk); #1;
    sha_if.start = 1'b0;
    sha_if.abort = 1'b0;
    check_val("abort_start_busy", 256'(sha_if.busy), 256'd0);
    repeat (70) @(posedge clk); #1;
    check_val("abort_start_no_run", sha_if.state_out, last_out);

    for (int r = 0; r < 8; r++) begin
      blk = rand_block();
      st = (r % 2 == 1) ? last_out : rand_state();
      extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 63)) : -1;
      run_block(blk, st, ref_compress(dut_view(blk), st), extra, -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    // Aborts in the final round and in the FINAL cycle, then a random point
    run_block(rand_block(), rand_state(), '0, -1, 63);
    run_block(rand_block(), rand_state(), '0, -1, 64);
    run_block(rand_block(), rand_state(), '0, -1, int'($urandom_range(0, 64)));
    blk = rand_block();
    st = rand_state();
    run_block(blk, st, ref_compress(dut_view(blk), st), -1, -1);

    // Reset while rounds are running
    sha_if.block_in = dut_view(ABC_BLK);
    sha_if.state_in = IV;
    sha_if.start = 1'b1;
    @(posedge clk); #1;
    sha_if.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 256'(sha_if.busy), 256'd0);
    check_val("midrst_done", 256'(sha_if.done), 256'd0);
    check_val("midrst_state_out", sha_if.state_out, 256'd0);
    last_out = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_val("post_rst_idle", 256'(sha_if.busy), 256'd0);
    run_block(dut_view(ABC_BLK), IV, ABC_DIG, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/scr1_sha256_core.md
Name: scr1_sha256_core

Overview:
- Iterative SHA-256 compression engine; sits directly downstream of the memory-mapped accelerator register file, which holds the 8 chaining-state words and 16 message words.
- On a start pulse it latches one 512-bit block plus the 256-bit chaining state and runs 64 rounds, one round per clock.
- Outputs the updated state (compression result plus feed-forward) for the register file to capture.
- No bus interface of its own; the register file owns all core (dmem) traffic.

Parameters:
- None. Widths are fixed by FIPS 180-4: 32-bit words, 16-word block, 8-word state, 64 rounds.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE, no done pulse.
- block_in  in  512  message words; W0 = [511:480] … W15 = [31:0].
- state_in  in  256  chaining state; H0 = [255:224] … H7 = [31:0].
- busy  out  1  high while a block is being processed.
- done  out  1  one-cycle pulse when state_out is valid.
- state_out  out  256  updated chaining state, same packing as state_in; holds until the next done or reset.

Behaviour:
- Reset (async, rst_n low):
  - FSM = IDLE; busy = 0; done = 0; state_out = 0.
  - Round counter, working registers a..h, W window and latched H all cleared.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - On start at edge N: latch W window[0..15] = block_in, Hq = state_in, a..h = state_in, round counter t = 0, go to ROUND.
  - busy rises after edge N.
- ROUND (edges N+1 … N+64), one round per edge:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[0].
  - T2 = Σ0(a) + Maj(a,b,c).
  - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions are mod 2^32; carries are discarded.
  - Schedule: every round the window shifts down by one word. Slot 15 receives σ1(W[14]) + W[9] + σ0(W[1]) + W[0], computed on every round regardless of t.
  - t increments each round; at t == 63 go to FINAL (no wrap).
- FINAL (edge N+65):
  - state_out[i] = Hq[i] + working var[i], mod 2^32.
  - done = 1 for exactly one cycle after edge N+65.
  - busy = 0 in the same cycle; go to IDLE.
- Latency: start sampled at edge N → done high in the cycle after edge N+65 (65 cycles).
- start while busy: ignored; no queueing.
- start during the done cycle: accepted, because the FSM is already in IDLE.
- abort in ROUND/FINAL: next edge → IDLE, busy = 0, done stays 0, state_out unchanged.
- abort and start in the same IDLE cycle: abort wins; start is ignored.
- Inputs are read only at the start edge; changing them mid-operation has no effect.
- K[0..63]: fixed constants, combinational lookup indexed by t.

Optional Feature:
- Macro: SCR1_SHA256_BYTE_SWAP_EN.
- Defined:
  - Each 32-bit word of block_in is byte-reversed at the latch edge, so software can write little-endian message bytes directly.
  - state_in and state_out are never swapped.
- Undefined: block_in is latched as-is.
- Timing and all other behaviour are identical in both builds.

Decomposition:
- Shared package scr1_sha256_pkg holds:
  - FSM state enum type_scr1_sha256_fsm_e.
  - IV constants SCR1_SHA256_H0..H7 (6a09e667 … 5be0cd19).
  - Round count constant SCR1_SHA256_ROUNDS = 64.
  - Functions for Σ0, Σ1, σ0, σ1, Ch, Maj.
- One sub-module: scr1_sha256_k_rom.
  - Input: 6-bit t. Output: 32-bit K[t].
  - Purely combinational case table.

Test Plan:
- "abc" block with IV:
  - Stimulus: W0 = 61626380, W1..W14 = 0, W15 = 00000018; state_in = IV; pulse start.
  - Response: done after exactly 65 cycles; state_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message with IV:
  - Stimulus: W0 = 80000000, all other words = 0.
  - Response: state_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- start while busy:
  - Stimulus: second start pulse at cycle 10.
  - Response: ignored; a single done at cycle 65; result equals the "abc" digest.
- Back-to-back:
  - Stimulus: start asserted in the done cycle, using the previous state_out as state_in.
  - Response: second done exactly 65 cycles later.
- abort at cycle 30:
  - Response: busy = 0 next cycle; no done; state_out retains its prior value; a following "abc" run still gives the correct digest.
- Reset mid-operation:
  - Stimulus: assert rst_n low at cycle 20.
  - Response: busy, done and state_out = 0 immediately; the engine is idle after release.
- Byte-swap build (SCR1_SHA256_BYTE_SWAP_EN defined):
  - Stimulus: W0 = 80636261.
  - Response: reproduces the "abc" digest.
